mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arbiter_rr_arb2.sv | 28 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the MCPU RAM arbiter: FSM state encoding and bus-owner tag.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE_CPU  = 3'd1,
    ST_ISSUE_HOST = 3'd2,
    ST_RESP_CPU   = 3'd3,
    ST_RESP_HOST  = 3'd4
  } state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  function automatic logic is_host_busy(input state_t s);
    return (s == ST_ISSUE_HOST) || (s == ST_RESP_HOST);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin pick: a lone request wins, a tie goes to the master
// that was not granted last. The CPU input can be masked out (host lock).
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   i_req_cpu,
  input  logic   i_req_host,
  input  logic   i_mask_cpu,
  input  owner_t i_last_grant,
  output logic   o_valid,
  output owner_t o_owner
);

  logic w_cpu_eligible;

  assign w_cpu_eligible = i_req_cpu & ~i_mask_cpu;

  always_comb begin
    o_valid = w_cpu_eligible | i_req_host;
    o_owner = OWN_CPU;
    if (w_cpu_eligible && i_req_host) begin
      o_owner = (i_last_grant == OWN_CPU) ? OWN_HOST : OWN_CPU;
    end else if (i_req_host) begin
      o_owner = OWN_HOST;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and host accesses to the single-port RAM: IDLE -> ISSUE -> RESP,
// alternating grants on contention and holding the CPU off during host bulk loads.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  output logic                 cpu_ack,
  output logic                 cpu_hold,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic [WORD_SIZE-1:0] host_rdata,
  output logic                 host_ack,
  input  logic                 host_lock,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_we,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  owner_t                 r_last_grant;
  logic                   r_cpu_hold;
  logic [ADDR_SIZE-1:0]   r_ram_addr;
  logic                   r_ram_we;
  logic [WORD_SIZE-1:0]   r_ram_wdata;
  logic                   w_gnt_valid;
  owner_t                 w_gnt_owner;
  logic                   w_capture;
  logic                   w_cpu_ack;
  logic                   w_host_ack;

  rr_arb2 u_rr_arb2 (
    .i_req_cpu    (cpu_req),
    .i_req_host   (host_req),
    .i_mask_cpu   (host_lock),
    .i_last_grant (r_last_grant),
    .o_valid      (w_gnt_valid),
    .o_owner      (w_gnt_owner)
  );

  // Arbitration only happens in IDLE; RESP always returns to IDLE so the
  // requester has a cycle to drop req before it could be re-granted.
  always_comb begin
    w_state_nxt = r_state;
    w_cpu_ack   = 1'b0;
    w_host_ack  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = (w_gnt_owner == OWN_CPU) ? ST_ISSUE_CPU : ST_ISSUE_HOST;
        end
      end
      ST_ISSUE_CPU:  w_state_nxt = ST_RESP_CPU;
      ST_ISSUE_HOST: w_state_nxt = ST_RESP_HOST;
      ST_RESP_CPU: begin
        w_cpu_ack   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RESP_HOST: begin
        w_host_ack  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= OWN_HOST;
      r_cpu_hold   <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_hold <= host_lock | is_host_busy(w_state_nxt);

      // Request fields are frozen at grant; later changes are ignored until ack.
      if (w_capture) begin
        if (w_gnt_owner == OWN_CPU) begin
          r_ram_addr  <= cpu_addr;
          r_ram_we    <= cpu_we;
          r_ram_wdata <= cpu_wdata;
        end else begin
          r_ram_addr  <= host_addr;
          r_ram_we    <= host_we;
          r_ram_wdata <= host_wdata;
        end
      end else begin
        r_ram_we <= 1'b0;
      end

      if (r_state == ST_RESP_CPU) begin
        r_last_grant <= OWN_CPU;
      end else if (r_state == ST_RESP_HOST) begin
        r_last_grant <= OWN_HOST;
      end
    end
  end

  assign ram_addr   = r_ram_addr;
  assign ram_we     = r_ram_we;
  assign ram_wdata  = r_ram_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign cpu_ack    = w_cpu_ack;
  assign host_ack   = w_host_ack;
  assign cpu_rdata  = ram_rdata;
  assign host_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

  localparam int WS = 16;
  localparam int AS = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AS-1:0] cpu_addr = '0;
  logic [WS-1:0] cpu_wdata = '0;
  logic [WS-1:0] cpu_rdata;
  logic          cpu_ack, cpu_hold;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AS-1:0] host_addr = '0;
  logic [WS-1:0] host_wdata = '0;
  logic [WS-1:0] host_rdata;
  logic          host_ack;
  logic          host_lock = 1'b0;
  logic [AS-1:0] ram_addr;
  logic          ram_we;
  logic [WS-1:0] ram_wdata;
  logic [WS-1:0] ram_rdata;

  logic [WS-1:0] mem [256] = '{default: 16'h0000};

  int n_checks = 0;
  int n_fail = 0;
  int mon_cpu_acks = 0;
  int mon_hold_lows = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  mem_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .cpu_hold   (cpu_hold),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .host_lock  (host_lock),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Called at a negedge with the arbiter idle; returns at the following idle negedge.
  task automatic host_access(input logic we, input logic [AS-1:0] addr, input logic [WS-1:0] wd,
                             output logic [WS-1:0] rd, output int lat);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    lat = 0; rd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (!cpu_hold) mon_hold_lows++;
      if (cpu_ack) mon_cpu_acks++;
      if (host_ack) begin
        rd = host_rdata;
        break;
      end
    end
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    if (!cpu_hold) mon_hold_lows++;
    if (cpu_ack) mon_cpu_acks++;
  endtask

  task automatic cpu_access(input logic we, input logic [AS-1:0] addr, input logic [WS-1:0] wd,
                            output logic [WS-1:0] rd, output int lat);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0; rd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_ack) begin
        rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_wdata !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_ram: got we=%0b addr=%h wdata=%h expected 0/00/0000", ram_we, ram_addr, ram_wdata);
    end
    n_checks++;
    if (cpu_ack !== 1'b0 || host_ack !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cpu_ack=%0b host_ack=%0b cpu_hold=%0b expected 0/0/0", cpu_ack, host_ack, cpu_hold);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_preload;
    logic [WS-1:0] rd;
    int lat;
    host_access(1'b1, 8'h14, 16'h1414, rd, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL preload_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_reset_mid_issue;
    logic [WS-1:0] rd;
    int lat;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h33; host_wdata = 16'hBEEF;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h33) begin
      n_fail++;
      $display("FAIL midreset_issue: got we=%0b addr=%h expected 1/33", ram_we, ram_addr);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (ram_we !== 1'b0 || ram_addr !== 8'h00 || host_ack !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got we=%0b addr=%h host_ack=%0b hold=%0b expected 0/00/0/0", ram_we, ram_addr, host_ack, cpu_hold);
    end
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_checks++;
    if (host_ack !== 1'b0 || mem[8'h33] !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_abandon: got host_ack=%0b mem33=%h expected 0/0000", host_ack, mem[8'h33]);
    end
    cpu_access(1'b0, 8'h14, 16'h0000, rd, lat);
    n_checks++;
    if (lat !== 2 || rd !== 16'h1414) begin
      n_fail++;
      $display("FAIL midreset_cpu_read: got lat=%0d data=%h expected 2/1414", lat, rd);
    end
  endtask

  task automatic test_write_read;
    logic [WS-1:0] rd;
    int lat;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h00; host_wdata = 16'h2103;
    @(negedge clk);
    n_checks++;
    if (ram_we !== 1'b1 || ram_addr !== 8'h00 || ram_wdata !== 16'h2103 || host_ack !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_issue: got we=%0b addr=%h wdata=%h ack=%0b hold=%0b expected 1/00/2103/0/1", ram_we, ram_addr, ram_wdata, host_ack, cpu_hold);
    end
    @(negedge clk);
    n_checks++;
    if (host_ack !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_resp: got ack=%0b we=%0b expected 1/0", host_ack, ram_we);
    end
    host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (host_ack !== 1'b0 || ram_we !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_idle: got ack=%0b we=%0b hold=%0b expected 0/0/0", host_ack, ram_we, cpu_hold);
    end
    cpu_access(1'b0, 8'h00, 16'h0000, rd, lat);
    n_checks++;
    if (lat !== 2 || rd !== 16'h2103) begin
      n_fail++;
      $display("FAIL wr_cpu_read: got lat=%0d data=%h expected 2/2103", lat, rd);
    end
  endtask

  task automatic test_cpu_write;
    logic [WS-1:0] rd;
    int lat;
    cpu_access(1'b1, 8'h40, 16'h5A5A, rd, lat);
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL cpuwr_latency: got %0d expected 2", lat);
    end
    host_access(1'b0, 8'h40, 16'h0000, rd, lat);
    n_checks++;
    if (rd !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL cpuwr_readback: got %h expected 5a5a", rd);
    end
  endtask

  task automatic test_contention;
    int ack_t [6];
    int ack_who [6];
    logic [WS-1:0] ack_data [6];
    int n_acks = 0;
    int t = 0;
    reset = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h14;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00;
    reset = 1'b1;
    for (int i = 0; i < 40 && n_acks < 6; i++) begin
      @(negedge clk);
      t++;
      if (cpu_ack && n_acks < 6) begin
        ack_t[n_acks] = t; ack_who[n_acks] = 0; ack_data[n_acks] = cpu_rdata; n_acks++;
      end
      if (host_ack && n_acks < 6) begin
        ack_t[n_acks] = t; ack_who[n_acks] = 1; ack_data[n_acks] = host_rdata; n_acks++;
      end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (n_acks !== 6) begin
      n_fail++;
      $display("FAIL contention_count: got %0d acks expected 6", n_acks);
    end
    for (int k = 0; k < n_acks; k++) begin
      n_checks++;
      if (ack_who[k] !== (k % 2) || ack_t[k] !== 2 + 3 * k ||
          ack_data[k] !== ((k % 2) == 0 ? 16'h1414 : 16'h2103)) begin
        n_fail++;
        $display("FAIL contention_ack%0d: got who=%0d cycle=%0d data=%h expected who=%0d cycle=%0d", k, ack_who[k], ack_t[k], ack_data[k], k % 2, 2 + 3 * k);
      end
    end
  endtask

  task automatic test_lock;
    logic [WS-1:0] rd;
    int lat;
    int bad_lat = 0;
    logic hold_first;
    host_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h14;
    @(negedge clk);
    n_checks++;
    if (cpu_hold !== 1'b1 || cpu_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_start: got hold=%0b ack=%0b expected 1/0", cpu_hold, cpu_ack);
    end
    mon_cpu_acks = 0; mon_hold_lows = 0;
    for (int i = 0; i < 10; i++) begin
      host_access(1'b1, 8'(i), 16'hA000 + 16'(i), rd, lat);
      if (lat != 2) bad_lat++;
    end
    for (int i = 0; i < 10; i++) begin
      host_access(1'b0, 8'(i), 16'h0000, rd, lat);
      if (lat != 2) bad_lat++;
      n_checks++;
      if (rd !== 16'hA000 + 16'(i)) begin
        n_fail++;
        $display("FAIL lock_readback%0d: got %h expected %h", i, rd, 16'hA000 + 16'(i));
      end
    end
    n_checks++;
    if (mon_cpu_acks !== 0 || mon_hold_lows !== 0 || bad_lat !== 0) begin
      n_fail++;
      $display("FAIL lock_exclusive: got cpu_acks=%0d hold_lows=%0d bad_latencies=%0d expected 0/0/0", mon_cpu_acks, mon_hold_lows, bad_lat);
    end
    host_lock = 1'b0;
    lat = 0; rd = '0; hold_first = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lat++;
      if (i == 0) hold_first = cpu_hold;
      if (cpu_ack) begin
        rd = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (hold_first !== 1'b0 || lat !== 2 || rd !== 16'h1414) begin
      n_fail++;
      $display("FAIL lock_release: got hold=%0b lat=%0d data=%h expected 0/2/1414", hold_first, lat, rd);
    end
  endtask

  task automatic test_lock_during_issue;
    int acks = 0;
    int lows = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    @(negedge clk);
    n_checks++;
    if (ram_addr !== 8'h05 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL lockissue_issue: got addr=%h hold=%0b expected 05/0", ram_addr, cpu_hold);
    end
    host_lock = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hA005 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL lockissue_ack: got ack=%0b data=%h hold=%0b expected 1/a005/1", cpu_ack, cpu_rdata, cpu_hold);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (!cpu_hold) lows++;
    end
    n_checks++;
    if (acks !== 0 || lows !== 0) begin
      n_fail++;
      $display("FAIL lockissue_blocked: got acks=%0d hold_lows=%0d expected 0/0", acks, lows);
    end
    cpu_req = 1'b0; host_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_drop_req;
    int acks = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h03;
    @(negedge clk);
    n_checks++;
    if (ram_addr !== 8'h03) begin
      n_fail++;
      $display("FAIL drop_issue_addr: got %h expected 03", ram_addr);
    end
    cpu_req = 1'b0; cpu_addr = 8'h07;
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hA003 || ram_addr !== 8'h03) begin
      n_fail++;
      $display("FAIL drop_ack: got ack=%0b data=%h addr=%h expected 1/a003/03", cpu_ack, cpu_rdata, ram_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL drop_no_regrant: got %0d extra acks expected 0", acks);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_reset_mid_issue();
    test_write_read();
    test_cpu_write();
    test_contention();
    test_lock();
    test_lock_during_issue();
    test_drop_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
